// File: rtl/delay_line_manager.sv
// Bit-serial manager for a recirculating delay line: bit timing, word framing, received-word port and
// one-shot replacement of outgoing words. Define DLM_MAJORITY_SAMPLE_EN for 3-point majority sampling.
`timescale 1ns / 1ps

module delay_line_manager #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned PW_WIDTH   = 8,
  parameter int unsigned PG_WIDTH   = 8,
  parameter int unsigned OVR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [ADDR_WIDTH-1:0] cfg_no_nums,
  input  logic [PW_WIDTH-1:0]   cfg_pulse_width,
  input  logic [PG_WIDTH-1:0]   cfg_pulse_gap,
  input  logic                  line_in,
  output logic                  line_out,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [OVR_WIDTH-1:0]  overrun_cnt
);

  // Two spare bits so W+G and 3*W never overflow the timer arithmetic.
  localparam int unsigned CtrW  = ((PW_WIDTH > PG_WIDTH) ? PW_WIDTH : PG_WIDTH) + 2;
  localparam int unsigned BitW  = $clog2(DATA_WIDTH);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  localparam logic [CtrW-1:0]       CtrOne  = CtrW'(1);
  localparam logic [BitW-1:0]       BitOne  = BitW'(1);
  localparam logic [BitW-1:0]       LastBit = BitW'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [OVR_WIDTH-1:0]  OvrOne  = OVR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] cfg_n_q;
  logic [CtrW-1:0]       cfg_w_q, cfg_g_q;

  logic [CtrW-1:0]       ctr_q, ctr_d;
  logic [BitW-1:0]       bit_ctr_q, bit_ctr_d;
  logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  mux_q, mux_d;
  logic [DATA_WIDTH-1:0] stage_data_q, stage_data_d;
  logic                  stage_pend_q, stage_pend_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [OVR_WIDTH-1:0]  ovr_q, ovr_d;
  logic [Depth-1:0]      pend_q, pend_d;
  logic                  run_q;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [CtrW-1:0]       period_last, samp_pos;
  logic                  oclk, rise_tick, fall_tick, samp_tick;
  logic                  last_bit, word_end, lookup;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  wr_fire;
  logic                  rx_shift, rx_bit;

  // Configuration follows the inputs only while held in reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cfg_n_q <= cfg_no_nums;
      cfg_w_q <= CtrW'(cfg_pulse_width);
      cfg_g_q <= CtrW'(cfg_pulse_gap);
    end
  end

  assign period_last = cfg_w_q + cfg_g_q - CtrOne;
  assign samp_pos    = cfg_g_q + (cfg_w_q >> 1);
  assign oclk        = (ctr_q >= cfg_g_q);
  assign rise_tick   = (ctr_q == cfg_g_q - CtrOne);
  assign fall_tick   = (ctr_q == period_last);
  assign samp_tick   = (ctr_q == samp_pos);

  assign last_bit  = (bit_ctr_q == LastBit);
  assign word_end  = rise_tick & last_bit;
  assign lookup    = fall_tick & last_bit;
  assign next_addr = (word_addr_q == cfg_n_q - AddrOne) ? '0 : word_addr_q + AddrOne;

  assign wr_ready = run_q & ~lookup;
  assign wr_fire  = wr_valid & wr_ready;

`ifdef DLM_MAJORITY_SAMPLE_EN
  logic [CtrW-1:0] q1_pos, q3_pos;
  logic            q1_tick, q3_tick;
  logic            s0_q, s1_q;
  logic            m0, m1;

  assign q1_pos  = cfg_g_q + (cfg_w_q >> 2);
  assign q3_pos  = cfg_g_q + ((cfg_w_q + (cfg_w_q << 1)) >> 2);
  assign q1_tick = (ctr_q == q1_pos);
  assign q3_tick = (ctr_q == q3_pos);
  // Sample points may coincide for narrow pulses; take the live input in that case.
  assign m0       = q1_tick ? line_in : s0_q;
  assign m1       = samp_tick ? line_in : s1_q;
  assign rx_shift = q3_tick;
  assign rx_bit   = (m0 & m1) | (m0 & line_in) | (m1 & line_in);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      if (q1_tick) s0_q <= line_in;
      if (samp_tick) s1_q <= line_in;
    end
  end
`else
  assign rx_shift = samp_tick;
  assign rx_bit   = line_in;
`endif

  always_comb begin
    ctr_d        = fall_tick ? '0 : ctr_q + CtrOne;
    bit_ctr_d    = bit_ctr_q;
    word_addr_d  = word_addr_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    mux_d        = mux_q;
    stage_data_d = stage_data_q;
    stage_pend_d = stage_pend_q;
    rd_valid_d   = rd_valid_q;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    ovr_d        = ovr_q;
    pend_d       = pend_q;

    if (rise_tick) begin
      bit_ctr_d = last_bit ? '0 : bit_ctr_q + BitOne;
      tx_d      = {tx_q[DATA_WIDTH-2:0], 1'b0};
    end
    if (rx_shift) rx_d = {rx_q[DATA_WIDTH-2:0], rx_bit};

    if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;
    if (word_end) begin
      word_addr_d = next_addr;
      tx_d        = stage_data_q;
      mux_d       = stage_pend_q;
      rd_valid_d  = 1'b1;
      rd_addr_d   = word_addr_q;
      rd_data_d   = rx_q;
      if (rd_valid_q && !rd_ready && (ovr_q != '1)) ovr_d = ovr_q + OvrOne;
    end

    // Lookup and write never share a cycle because wr_ready drops on lookup.
    if (lookup) begin
      stage_data_d      = mem_q[next_addr];
      stage_pend_d      = pend_q[next_addr];
      pend_d[next_addr] = 1'b0;
    end
    if (wr_fire) pend_d[wr_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ctr_q        <= '0;
      bit_ctr_q    <= '0;
      word_addr_q  <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      mux_q        <= 1'b0;
      stage_data_q <= '0;
      stage_pend_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      ovr_q        <= '0;
      pend_q       <= '0;
      run_q        <= 1'b0;
    end else begin
      ctr_q        <= ctr_d;
      bit_ctr_q    <= bit_ctr_d;
      word_addr_q  <= word_addr_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      mux_q        <= mux_d;
      stage_data_q <= stage_data_d;
      stage_pend_q <= stage_pend_d;
      rd_valid_q   <= rd_valid_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      ovr_q        <= ovr_d;
      pend_q       <= pend_d;
      run_q        <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_addr] <= wr_data;
  end

  assign line_out    = (mux_q ? tx_q[DATA_WIDTH-1] : line_in) & oclk;
  assign rd_valid    = rd_valid_q;
  assign rd_addr     = rd_addr_q;
  assign rd_data     = rd_data_q;
  assign overrun_cnt = ovr_q;

endmodule
